// File: rtl/aes_pkg.sv
// Shared definitions for the AES job arbiter: operand width, FSM encoding,
// requester id type and the two-way round-robin pick.
package aes_pkg;

   localparam int AES_W = 128;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } aes_state_e;

   typedef logic req_id_t;

   localparam req_id_t REQ_A = 1'b0;
   localparam req_id_t REQ_B = 1'b1;

   // With both requesters pending the pointer decides; a lone requester always wins.
   function automatic req_id_t rr_pick(input logic req_a, input logic req_b, input req_id_t ptr);
      if (req_a && req_b) begin
         return ptr;
      end else if (req_b) begin
         return REQ_B;
      end else begin
         return REQ_A;
      end
   endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Two-way round-robin arbiter: picks requester A or B and moves the pointer
// to the loser whenever a grant is actually accepted.
module aes_rr_arb
   import aes_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_a_i,
   input  logic req_b_i,
   input  logic accept_i,
   output logic grant_valid_o,
   output logic grant_id_o
);

   req_id_t ptr_q;
   req_id_t ptr_d;

   assign grant_valid_o = req_a_i | req_b_i;
   assign grant_id_o    = rr_pick(req_a_i, req_b_i, ptr_q);

   always_comb begin
      ptr_d = ptr_q;
      if (accept_i) begin
         ptr_d = ~grant_id_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= REQ_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one AES core between two requesters: accepts one job at a time,
// drives the core's load/start strobes, waits with a timeout, returns the result.
module aes_arbiter
   import aes_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic             a_dec,
   input  logic [AES_W-1:0] a_data,
   input  logic [AES_W-1:0] a_key,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic             b_dec,
   input  logic [AES_W-1:0] b_data,
   input  logic [AES_W-1:0] b_key,
   output logic             b_ready,
   output logic             res_valid,
   output logic             res_id,
   output logic [AES_W-1:0] res_data,
   output logic             res_err,
   input  logic             res_ready,
   output logic             aes_enable,
   output logic             aes_enc_req,
   output logic             aes_dec_req,
   output logic [AES_W-1:0] aes_key,
   output logic [AES_W-1:0] aes_data,
   input  logic [AES_W-1:0] aes_data_out,
   input  logic             aes_data_ready,
   output logic [2:0]       dbg_state_o
);

   // Handshake: a requester's job transfers on the rising edge where valid and
   // ready are both high; ready is only ever high in IDLE, for the granted side.

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_LOAD  = ST_LOAD;
   localparam logic [2:0] S_START = ST_START;
   localparam logic [2:0] S_WAIT  = ST_WAIT;
   localparam logic [2:0] S_RESP  = ST_RESP;

   localparam logic [CNT_W-1:0] TMO_LAST = 16'(TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic             id_q, id_d;
   logic             dec_q, dec_d;
   logic [AES_W-1:0] key_q, key_d;
   logic [AES_W-1:0] data_q, data_d;
   logic [AES_W-1:0] res_data_q, res_data_d;
   logic             res_err_q, res_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic grant_valid;
   logic grant_id;
   logic accept;

   aes_rr_arb u_rr (
      .clk           (clk),
      .rst           (rst),
      .req_a_i       (a_valid),
      .req_b_i       (b_valid),
      .accept_i      (accept),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   // Gated by rst so no ready escapes while reset is held.
   assign accept  = (state_q == S_IDLE) && grant_valid && !rst;
   assign a_ready = accept && (grant_id == REQ_A);
   assign b_ready = accept && (grant_id == REQ_B);

   assign aes_enable  = (state_q == S_LOAD);
   assign aes_enc_req = (state_q == S_START) && !dec_q;
   assign aes_dec_req = (state_q == S_START) && dec_q;
   assign aes_key     = key_q;
   assign aes_data    = data_q;

   assign res_valid   = (state_q == S_RESP);
   assign res_id      = id_q;
   assign res_data    = res_data_q;
   assign res_err     = res_err_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      dec_d      = dec_q;
      key_d      = key_q;
      data_d     = data_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               id_d       = grant_id;
               dec_d      = (grant_id == REQ_B) ? b_dec  : a_dec;
               key_d      = (grant_id == REQ_B) ? b_key  : a_key;
               data_d     = (grant_id == REQ_B) ? b_data : a_data;
               res_data_d = '0;
               res_err_d  = 1'b0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = S_START;
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the timeout cycle still counts as success.
            if (aes_data_ready) begin
               res_data_d = aes_data_out;
               res_err_d  = 1'b0;
               state_d    = S_RESP;
            end else if (cnt_q == TMO_LAST) begin
               res_data_d = '0;
               res_err_d  = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RESP: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         id_q       <= REQ_A;
         dec_q      <= 1'b0;
         key_q      <= '0;
         data_q     <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         dec_q      <= dec_d;
         key_q      <= key_d;
         data_q     <= data_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter: behavioural AES core with 70-cycle latency on
// the main instance, plus a TIMEOUT=8 instance with a hand-driven core interface.
module tb_aes_arbiter;

   localparam logic [127:0] K1 = 128'h5e74e7ba66b0c7cc1b7697b3f9f51527;
   localparam logic [127:0] P1 = 128'h7d8ae0f7cfa0a6cb09fb5d05a8ec586d;
   localparam logic [127:0] C1 = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
   localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] DA = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KB = 128'hf0e0d0c0b0a090807060504030201000;
   localparam logic [127:0] DB = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] X1 = 128'h11111111111111111111111111111111;
   localparam logic [127:0] X2 = 128'h2222222222222222222222222222222a;
   localparam logic [127:0] X3 = 128'h3333333333333333333333333333333c;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         a_valid = 1'b0, a_dec = 1'b0, b_valid = 1'b0, b_dec = 1'b0;
   logic [127:0] a_data = '0, a_key = '0, b_data = '0, b_key = '0;
   logic         res_ready = 1'b0;
   logic         a_ready, b_ready, res_valid, res_id, res_err;
   logic [127:0] res_data, aes_key, aes_data;
   logic         aes_enable, aes_enc_req, aes_dec_req;
   logic [127:0] aes_data_out = '0;
   logic         aes_data_ready = 1'b0;
   logic [2:0]   dbg_state;

   logic         t_a_valid = 1'b0, t_b_valid = 1'b0, t_res_ready = 1'b0, t_rdy = 1'b0;
   logic [127:0] t_out = '0;
   logic         t_a_ready, t_b_ready, t_res_valid, t_res_id, t_res_err;
   logic [127:0] t_res_data, t_key, t_data;
   logic         t_en, t_enc, t_dec;
   logic [2:0]   t_state;

   aes_arbiter #(.TIMEOUT(255)) u_dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_dec(a_dec), .a_data(a_data), .a_key(a_key), .a_ready(a_ready),
      .b_valid(b_valid), .b_dec(b_dec), .b_data(b_data), .b_key(b_key), .b_ready(b_ready),
      .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_err(res_err),
      .res_ready(res_ready),
      .aes_enable(aes_enable), .aes_enc_req(aes_enc_req), .aes_dec_req(aes_dec_req),
      .aes_key(aes_key), .aes_data(aes_data),
      .aes_data_out(aes_data_out), .aes_data_ready(aes_data_ready),
      .dbg_state_o(dbg_state)
   );

   aes_arbiter #(.TIMEOUT(8)) u_dut_t8 (
      .clk(clk), .rst(rst),
      .a_valid(t_a_valid), .a_dec(a_dec), .a_data(a_data), .a_key(a_key), .a_ready(t_a_ready),
      .b_valid(t_b_valid), .b_dec(b_dec), .b_data(b_data), .b_key(b_key), .b_ready(t_b_ready),
      .res_valid(t_res_valid), .res_id(t_res_id), .res_data(t_res_data), .res_err(t_res_err),
      .res_ready(t_res_ready),
      .aes_enable(t_en), .aes_enc_req(t_enc), .aes_dec_req(t_dec),
      .aes_key(t_key), .aes_data(t_data),
      .aes_data_out(t_out), .aes_data_ready(t_rdy),
      .dbg_state_o(t_state)
   );

   // Behavioural AES core: the known vector pair, otherwise a simple keyed XOR.
   function automatic logic [127:0] core_model(input logic dec, input logic [127:0] k,
                                               input logic [127:0] d);
      if (!dec && k == K1 && d == P1) return C1;
      if (dec && k == K1 && d == C1) return P1;
      return dec ? (d ^ ~k) : (d ^ k);
   endfunction

   logic [6:0]   core_cnt = '0;
   logic [127:0] core_res = '0;
   always @(posedge clk) begin
      aes_data_ready <= 1'b0;
      if (aes_enc_req || aes_dec_req) begin
         core_cnt <= 7'd70;
         core_res <= core_model(aes_dec_req, aes_key, aes_data);
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 7'd1;
         if (core_cnt == 7'd1) begin
            aes_data_ready <= 1'b1;
            aes_data_out   <= core_res;
         end
      end
   end

   int n_en = 0, n_enc = 0, n_dec = 0, n_overlap = 0, n_done = 0;
   always @(posedge clk) begin
      if (aes_enable) n_en <= n_en + 1;
      if (aes_enc_req) n_enc <= n_enc + 1;
      if (aes_dec_req) n_dec <= n_dec + 1;
      if (a_ready && b_ready) n_overlap <= n_overlap + 1;
      if (res_valid && res_ready) n_done <= n_done + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res(input string tag);
      int cyc;
      cyc = 0;
      while (!res_valid && cyc < 300) begin
         tick();
         cyc++;
      end
      check_eq(tag, res_valid, 1'b1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int           en0, enc0, dec0, done0, seen;
   logic [127:0] snap;

   initial begin
      // Reset, with a requester already valid: nothing may be accepted.
      a_valid = 1'b1;
      repeat (3) tick();
      check_eq("rst_ready", {a_ready, b_ready}, 2'b00);
      check_eq("rst_ctrl", {res_valid, res_id, res_err, aes_enable, aes_enc_req, aes_dec_req}, '0);
      check_eq("rst_res_data", res_data, '0);
      check_eq("rst_aes_key", aes_key, '0);
      check_eq("rst_aes_data", aes_data, '0);
      a_valid = 1'b0;
      rst = 1'b0;
      tick();

      // A encrypts the known vector.
      en0 = n_en; enc0 = n_enc; dec0 = n_dec;
      a_dec = 1'b0; a_key = K1; a_data = P1; a_valid = 1'b1;
      #1;
      check_eq("t1_accept", {a_ready, b_ready}, 2'b10);
      tick();
      a_valid = 1'b0; a_key = '0; a_data = '1;
      #1;
      check_eq("t1_load_en", aes_enable, 1'b1);
      check_eq("t1_load_key", aes_key, K1);
      check_eq("t1_load_data", aes_data, P1);
      check_eq("t1_ready_drop", a_ready, 1'b0);
      tick();
      check_eq("t1_start", {aes_enable, aes_enc_req, aes_dec_req}, 3'b010);
      tick();
      check_eq("t1_wait_state", dbg_state, 3'd3);
      check_eq("t1_wait_data_held", aes_data, P1);
      wait_res("t1_res_seen");
      check_eq("t1_res_data", res_data, C1);
      check_eq("t1_res_id_err", {res_id, res_err}, 2'b00);
      check_eq("t1_strobes", {32'(n_en - en0), 32'(n_enc - enc0), 32'(n_dec - dec0)}, {32'd1, 32'd1, 32'd0});
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      check_eq("t1_res_done", res_valid, 1'b0);

      // B decrypts it back.
      b_dec = 1'b1; b_key = K1; b_data = C1; b_valid = 1'b1;
      #1;
      check_eq("t2_accept", {a_ready, b_ready}, 2'b01);
      tick();
      b_valid = 1'b0;
      tick();
      check_eq("t2_start", {aes_enc_req, aes_dec_req}, 2'b01);
      wait_res("t2_res_seen");
      check_eq("t2_res_data", res_data, P1);
      check_eq("t2_res_id_err", {res_id, res_err}, 2'b10);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Both valid for four jobs: pointer is back at A, so A,B,A,B.
      a_dec = 1'b0; a_key = KA; a_data = DA;
      b_dec = 1'b1; b_key = KB; b_data = DB;
      a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         int cyc;
         cyc = 0;
         #1;
         while (!(a_ready || b_ready) && cyc < 20) begin
            tick();
            cyc++;
         end
         check_eq($sformatf("rr_grant%0d", j), {a_ready, b_ready}, (j % 2 == 0) ? 2'b10 : 2'b01);
         tick();
         wait_res($sformatf("rr_res_seen%0d", j));
         check_eq($sformatf("rr_res_id%0d", j), res_id, (j % 2 == 0) ? 1'b0 : 1'b1);
         check_eq($sformatf("rr_res_data%0d", j), res_data, (j % 2 == 0) ? (DA ^ KA) : (DB ^ ~KB));
         if (j == 3) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
         end
         tick();
      end
      res_ready = 1'b0;
      check_eq("rr_no_overlap", n_overlap, 0);

      // Response back-pressure: result must hold for 20 cycles with B waiting.
      a_valid = 1'b1;
      #1;
      check_eq("bp_accept", a_ready, 1'b1);
      tick();
      a_valid = 1'b0;
      wait_res("bp_res_seen");
      snap = res_data;
      check_eq("bp_res_data", snap, DA ^ KA);
      b_valid = 1'b1;
      done0 = n_done;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq($sformatf("bp_hold%0d", i), {res_valid, res_id, res_err, a_ready, b_ready}, 5'b10000);
         check_eq($sformatf("bp_data%0d", i), res_data, snap);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      check_eq("bp_single_done", n_done - done0, 1);
      check_eq("bp_next_accept", {res_valid, b_ready}, 2'b01);
      tick();
      b_valid = 1'b0;
      wait_res("bp_b_res_seen");
      check_eq("bp_b_res", {res_id, res_data}, {1'b1, DB ^ ~KB});
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Reset during WAIT drops the job; the late core result must be ignored.
      a_key = K1; a_data = P1; a_dec = 1'b0; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      check_eq("rw_in_wait", dbg_state, 3'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_eq("rw_ctrl_zero", {a_ready, b_ready, res_valid, res_id, res_err,
                                aes_enable, aes_enc_req, aes_dec_req}, '0);
      check_eq("rw_key_zero", aes_key, '0);
      check_eq("rw_data_zero", aes_data, '0);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (res_valid) seen++;
      end
      check_eq("rw_no_response", seen, 0);
      a_valid = 1'b1;
      #1;
      check_eq("rw_fresh_accept", a_ready, 1'b1);
      tick();
      a_valid = 1'b0;
      wait_res("rw_res_seen");
      check_eq("rw_res", {res_id, res_err, res_data}, {2'b00, C1});
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // TIMEOUT=8 instance: silent core aborts eight cycles after WAIT entry.
      a_key = KA; a_data = DA; a_dec = 1'b0;
      t_a_valid = 1'b1;
      #1;
      check_eq("to_accept", {t_a_ready, t_b_ready}, 2'b10);
      tick();
      t_a_valid = 1'b0;
      tick();
      tick();
      check_eq("to_wait_state", t_state, 3'd3);
      repeat (7) tick();
      check_eq("to_not_yet", t_res_valid, 1'b0);
      tick();
      check_eq("to_res", {t_res_valid, t_res_err, t_res_id}, 3'b110);
      check_eq("to_res_data", t_res_data, '0);
      t_res_ready = 1'b1;
      tick();
      t_res_ready = 1'b0;

      // Next job: ready outside WAIT ignored, ready on the timeout cycle wins.
      t_a_valid = 1'b1;
      #1;
      check_eq("to2_accept", t_a_ready, 1'b1);
      tick();
      t_a_valid = 1'b0; t_rdy = 1'b1; t_out = X1;
      #1;
      check_eq("to2_load", {t_en, t_key, t_data}, {1'b1, KA, DA});
      tick();
      check_eq("to2_start", {t_enc, t_dec}, 2'b10);
      tick();
      t_rdy = 1'b0;
      #1;
      check_eq("to2_early_ignored", t_res_valid, 1'b0);
      repeat (7) tick();
      t_rdy = 1'b1; t_out = X2;
      #1;
      check_eq("to2_last_wait", t_res_valid, 1'b0);
      tick();
      t_rdy = 1'b0;
      check_eq("to2_res", {t_res_valid, t_res_err}, 2'b10);
      check_eq("to2_res_data", t_res_data, X2);
      t_res_ready = 1'b1;
      tick();
      t_res_ready = 1'b0;

      // Minimum latency: core answers in the first WAIT cycle.
      t_a_valid = 1'b1;
      tick();
      t_a_valid = 1'b0;
      tick();
      tick();
      t_rdy = 1'b1; t_out = X3;
      #1;
      check_eq("lat_wait", t_res_valid, 1'b0);
      tick();
      t_rdy = 1'b0;
      check_eq("lat_res", {t_res_valid, t_res_err, t_res_data}, {2'b10, X3});
      t_res_ready = 1'b1;
      tick();
      t_res_ready = 1'b0;
      #1;
      check_eq("lat_done", t_res_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum WAIT-state cycles before a job is aborted (range 1..65535).
REQ-002 clk  in  1  single system clock; all logic SHALL be rising-edge clk.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 a_valid/b_valid  in  1  requester A/B holds a job.
REQ-005 a_dec/b_dec  in  1  1 = decrypt, 0 = encrypt.
REQ-006 a_data/b_data  in  128  requester block.
REQ-007 a_key/b_key  in  128  requester key.
REQ-008 a_ready/b_ready  out  1  job accepted when valid&ready.
REQ-009 res_valid  out  1; res_id  out  1 (0=A, 1=B); res_data  out  128; res_err  out  1 (timeout); res_ready  in  1.
REQ-010 aes_enable, aes_enc_req, aes_dec_req  out  1  single-cycle strobes to the AES core.
REQ-011 aes_key, aes_data  out  128  operands to the AES core.
REQ-012 aes_data_out  in  128; aes_data_ready  in  1  result from the AES core.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, START, WAIT, RESP.
REQ-014 IDLE: with any valid, the block SHALL assert the selected requester's ready for exactly one cycle, latch its id/dec/data/key, and go to LOAD.
REQ-015 Both valid in the same cycle: the requester named by the round-robin pointer SHALL win; the pointer resets to A.
REQ-016 The pointer SHALL move to the non-winner on each accept; a lone valid requester SHALL win regardless of the pointer.
REQ-017 LOAD: aes_enable=1 for one cycle with aes_key/aes_data = latched values; then START.
REQ-018 START: exactly one of aes_enc_req/aes_dec_req=1 for one cycle per latched dec; then WAIT.
REQ-019 aes_key/aes_data SHALL hold latched values from LOAD through WAIT; requester input changes after accept SHALL have no effect.
REQ-020 WAIT: a 16-bit counter cleared on entry SHALL increment per cycle; the first cycle with aes_data_ready=1 SHALL capture aes_data_out into res_data, res_err=0, go to RESP.
REQ-021 WAIT: if counter reaches TIMEOUT without aes_data_ready, res_data=0, res_err=1, go to RESP; ready and timeout in the same cycle SHALL resolve as success.
REQ-022 aes_data_ready outside WAIT SHALL be ignored.
REQ-023 RESP: res_valid=1 and res_id/res_data/res_err stable until res_ready=1; that cycle completes and returns to IDLE.
REQ-024 No new job SHALL be accepted before RESP completes; one job in flight maximum.
REQ-025 Minimum latency: accept cycle to res_valid SHALL be 3 cycles plus core latency (LOAD, START, WAIT≥1).
REQ-026 a_ready/b_ready SHALL be 0 in all states except the IDLE accept cycle.

Reset
REQ-027 rst=1 at any clock edge SHALL force IDLE, pointer=A, counter=0, and all outputs (readies, strobes, res_*, aes_key, aes_data) to 0.
REQ-028 Reset mid-job SHALL drop the job with no response; the requester re-presents it.

Structure
REQ-029 Package aes_pkg SHALL hold AES_W=128, the FSM state enum, and the requester-id typedef.
REQ-030 The two-way round-robin pick and pointer SHALL be sub-module aes_rr_arb; FSM, latches and counter stay in aes_arbiter.

Verification (behavioural AES core model, latency 70 cycles, unless noted)
REQ-031 A only, enc, key 5e74e7ba66b0c7cc1b7697b3f9f51527, data 7d8ae0f7cfa0a6cb09fb5d05a8ec586d -> one aes_enable then one aes_enc_req; res_data deb0f81341f3503a7cd01e2bc7cdd556, res_id=0, res_err=0.
REQ-032 B only, dec, same key, data deb0f81341f3503a7cd01e2bc7cdd556 -> aes_dec_req; res_data 7d8ae0f7cfa0a6cb09fb5d05a8ec586d, res_id=1.
REQ-033 A and B valid together, held through 4 jobs -> grant order A,B,A,B; no ready overlap.
REQ-034 Core never asserts data_ready, TIMEOUT=8 -> res_err=1, res_data=0 eight cycles after WAIT entry; next job proceeds normally.
REQ-035 res_ready held low 20 cycles -> res_* stable, both readies 0; then single completion.
REQ-036 rst pulsed during WAIT -> all outputs 0 next cycle, no res_valid; fresh A job afterward completes correctly.
